alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Keeps the MIPS ALU op encoding: AND, OR, ADD, SUB, SLT.
- Adds logical shifts, an iterative unsigned multiply (shift-add, WIDTH cycles), carry/overflow flags and a valid/ready handshake.
- Sits between the decode stage and the writeback mux of the multi-cycle datapath.

---
 rtl/alu_seq.sv | 151 +++++++++++++++
 tb/tb_alu_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered MIPS-style ALU with logical shifts and an iterative shift-add unsigned multiply.
// Single-cycle ops complete in one edge; MULTU occupies the unit for WIDTH further edges.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_SLL   = 3'b100;
  localparam logic [2:0] OP_SRL   = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH:0]       partial;
  logic [SHW:0]         cnt;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry, alu_ovf;
  logic                 load_mul, step, done_single, done_mul;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL: alu_res = a << b[SHW-1:0];
      OP_SRL: alu_res = a >> b[SHW-1:0];
      OP_SUB: begin
        // carry reports no-borrow, i.e. a >= b unsigned
        alu_res   = diff[WIDTH-1:0];
        alu_carry = ~diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: the carry out of the upper half shifts back in as the new MSB
  assign partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_step = {partial, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    load_mul    = 1'b0;
    step        = 1'b0;
    done_single = 1'b0;
    done_mul    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op == OP_MULTU) begin
            load_mul   = 1'b1;
            state_next = MUL;
          end else begin
            done_single = 1'b1;
          end
        end
      end
      MUL: begin
        step = 1'b1;
        if (cnt == (SHW+1)'(1)) begin
          done_mul   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= done_single | done_mul;
      if (load_mul) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= (SHW+1)'(WIDTH);
      end
      if (step) begin
        acc    <= acc_step;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end
      if (done_single) begin
        result    <= alu_res;
        result_hi <= '0;
        zero      <= (alu_res == '0);
        carry     <= alu_carry;
        overflow  <= alu_ovf;
      end
      if (done_mul) begin
        {result_hi, result} <= acc_step;
        zero     <= (acc_step == '0);
        carry    <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a 4-bit and a 32-bit instance share clock and reset,
// and every completion is compared with an integer-arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv4, ir4, ov4, z4, c4, v4;
  logic [2:0]  op4;
  logic [3:0]  a4, b4, r4, rh4;
  logic        iv32, ir32, ov32, z32, c32, v32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, r32, rh32;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op4), .a(a4), .b(b4),
    .out_valid(ov4), .result(r4), .result_hi(rh4), .zero(z4), .carry(c4), .overflow(v4)
  );

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32), .a(a32), .b(b32),
    .out_valid(ov32), .result(r32), .result_hi(rh32), .zero(z32), .carry(c32), .overflow(v32)
  );

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic        z, c, v;
  } exp_t;

  // Reference model built from plain integer arithmetic on w-bit values
  function automatic exp_t model(input int w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    logic [63:0] mask, t;
    longint sx, sy;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    sh = int'(y % 64'(w));
    sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0;
    case (o)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd2: begin
        t = x + y;
        e.res = t & mask;
        e.c = t[w];
        e.v = (x[w-1] == y[w-1]) && (e.res[w-1] != x[w-1]);
      end
      3'd3: begin
        t = x * y;
        e.res = t & mask;
        e.hi = (t >> w) & mask;
      end
      3'd4: e.res = (x << sh) & mask;
      3'd5: e.res = x >> sh;
      3'd6: begin
        e.res = (x - y) & mask;
        e.c = (x >= y);
        e.v = (x[w-1] != y[w-1]) && (e.res[w-1] != x[w-1]);
      end
      default: e.res = (sx < sy) ? 64'd1 : 64'd0;
    endcase
    e.z = (e.res == 0) && (e.hi == 0);
    return e;
  endfunction

  task automatic applyStimulus32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [31:0] rh, output logic z, output logic c,
                                 output logic v, output int lat, output bit ok);
    int n = 0;
    while (!ir32 && n < 100) begin @(negedge clk); n++; end
    op32 = o; a32 = x; b32 = y; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
    lat = 0;
    while (!ov32 && lat < 100) begin @(negedge clk); lat++; end
    ok = ov32; r = r32; rh = rh32; z = z32; c = c32; v = v32;
  endtask

  task automatic applyStimulus4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                                output logic [3:0] r, output logic [3:0] rh, output logic z, output logic c,
                                output logic v, output int lat, output bit ok);
    int n = 0;
    while (!ir4 && n < 100) begin @(negedge clk); n++; end
    op4 = o; a4 = x; b4 = y; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0; op4 = 3'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!ov4 && lat < 100) begin @(negedge clk); lat++; end
    ok = ov4; r = r4; rh = rh4; z = z4; c = c4; v = v4;
  endtask

  task automatic test_reset();
    checks++;
    if ({ir4, ov4, r4, rh4, z4, c4, v4} !== {1'b1, 12'b0}) begin
      errors++;
      $display("[TB] FAIL reset4 got %b expected %b", {ir4, ov4, r4, rh4, z4, c4, v4}, {1'b1, 12'b0});
    end
    checks++;
    if ({ir32, ov32, r32, rh32, z32, c32, v32} !== {1'b1, 68'b0}) begin
      errors++;
      $display("[TB] FAIL reset32 got %h expected %h", {ir32, ov32, r32, rh32, z32, c32, v32}, {1'b1, 68'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] to [6];
    logic [3:0] ta [6];
    logic [3:0] tb [6];
    logic [3:0] tr [6];
    exp_t e;
    to = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7, 3'd7};
    ta = '{4'b0111, 4'b0101, 4'b0111, 4'b1111, 4'b0101, 4'b1110};
    tb = '{4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b1111};
    tr = '{4'b0001, 4'b0111, 4'b1000, 4'b1110, 4'b0000, 4'b0001};
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        e = model(4, to[i-1], 64'(ta[i-1]), 64'(tb[i-1]));
        checks++;
        if (ov4 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_valid[%0d] got %b expected 1", i-1, ov4);
        end
        checks++;
        if ({r4, rh4, z4, c4, v4} !== {e.res[3:0], e.hi[3:0], e.z, e.c, e.v} || r4 !== tr[i-1]) begin
          errors++;
          $display("[TB] FAIL b2b_out[%0d] got %b expected %b", i-1, {r4, rh4, z4, c4, v4},
                   {e.res[3:0], e.hi[3:0], e.z, e.c, e.v});
        end
      end
      checks++;
      if (ir4 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_ready[%0d] got %b expected 1", i, ir4);
      end
      if (i < 6) begin
        op4 = to[i]; a4 = ta[i]; b4 = tb[i]; iv4 = 1'b1;
      end else begin
        iv4 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_multu4();
    int first = -1, pulses = 0, readyErr = 0;
    logic [3:0] rr, rrh;
    logic rz;
    op4 = 3'd3; a4 = 4'hF; b4 = 4'hF; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    rr = '0; rrh = '0; rz = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (ov4) begin
        pulses++;
        if (first < 0) begin first = k; rr = r4; rrh = rh4; rz = z4; end
      end
      if (k < 4 && ir4 !== 1'b0) readyErr++;
      if (k == 1) begin op4 = 3'd2; a4 = 4'd1; b4 = 4'd1; iv4 = 1'b1; end
      if (k == 2) iv4 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({rrh, rr, rz} !== {4'b1110, 4'b0001, 1'b0}) begin
      errors++;
      $display("[TB] FAIL multu4_val got %b expected %b", {rrh, rr, rz}, {4'b1110, 4'b0001, 1'b0});
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("[TB] FAIL multu4_latency got %0d expected 4 negedges after accept", first);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL multu4_pulses got %0d expected 1", pulses);
    end
    checks++;
    if (readyErr != 0) begin
      errors++;
      $display("[TB] FAIL multu4_ready_low got %0d bad cycles expected 0", readyErr);
    end
  endtask

  task automatic test_directed32();
    logic [2:0]  dop [7];
    logic [31:0] da [7];
    logic [31:0] db [7];
    logic [31:0] dr [7];
    logic [31:0] dh [7];
    logic [2:0]  df [7];
    int          dl [7];
    logic [31:0] r, rh;
    logic z, c, v, ok;
    int lat;
    exp_t e;
    dop = '{3'd3, 3'd3, 3'd4, 3'd5, 3'd4, 3'd2, 3'd2};
    da  = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h8000_0000, 32'hA5A5_1234, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    db  = '{32'h2, 32'h1234, 32'h21, 32'd31, 32'h0, 32'h1, 32'h1};
    dr  = '{32'hFFFF_FFFE, 32'h0, 32'h2, 32'h1, 32'hA5A5_1234, 32'h8000_0000, 32'h0};
    dh  = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    df  = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b001, 3'b110};
    dl  = '{32, 32, 0, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      applyStimulus32(dop[i], da[i], db[i], r, rh, z, c, v, lat, ok);
      e = model(32, dop[i], 64'(da[i]), 64'(db[i]));
      checks++;
      if (!ok || lat != dl[i]) begin
        errors++;
        $display("[TB] FAIL dir32_latency[%0d] got %0d valid=%b expected %0d", i, lat, ok, dl[i]);
      end
      checks++;
      if ({rh, r, z, c, v} !== {dh[i], dr[i], df[i]} || {rh, r, z, c, v} !== {e.hi[31:0], e.res[31:0], e.z, e.c, e.v}) begin
        errors++;
        $display("[TB] FAIL dir32_out[%0d] got %h_%h zcv=%b expected %h_%h zcv=%b", i, rh, r, {z, c, v}, dh[i], dr[i], df[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, rh, x, y;
    logic [3:0] r4l, rh4l;
    logic z, c, v, ok;
    logic [2:0] o;
    int lat;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      applyStimulus32(o, x, y, r, rh, z, c, v, lat, ok);
      e = model(32, o, 64'(x), 64'(y));
      checks++;
      if (!ok || lat != ((o == 3'd3) ? 32 : 0) || {rh, r, z, c, v} !== {e.hi[31:0], e.res[31:0], e.z, e.c, e.v}) begin
        errors++;
        $display("[TB] FAIL rand32[%0d] op=%0d a=%h b=%h got %h_%h zcv=%b lat=%0d expected %h_%h zcv=%b", i, o, x, y,
                 rh, r, {z, c, v}, lat, e.hi[31:0], e.res[31:0], {e.z, e.c, e.v});
      end
    end
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 32'($urandom_range(0, 15));
      y = 32'($urandom_range(0, 15));
      applyStimulus4(o, x[3:0], y[3:0], r4l, rh4l, z, c, v, lat, ok);
      e = model(4, o, 64'(x), 64'(y));
      checks++;
      if (!ok || lat != ((o == 3'd3) ? 4 : 0) || {rh4l, r4l, z, c, v} !== {e.hi[3:0], e.res[3:0], e.z, e.c, e.v}) begin
        errors++;
        $display("[TB] FAIL rand4[%0d] op=%0d a=%h b=%h got %h_%h zcv=%b lat=%0d expected %h_%h zcv=%b", i, o, x[3:0],
                 y[3:0], rh4l, r4l, {z, c, v}, lat, e.hi[3:0], e.res[3:0], {e.z, e.c, e.v});
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] r, rh;
    logic z, c, v, ok, busy;
    int lat, stale;
    applyStimulus32(3'd2, 32'd5, 32'd6, r, rh, z, c, v, lat, ok);
    op32 = 3'd3; a32 = 32'hDEAD_BEEF; b32 = 32'h0001_2345; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    busy = ir32;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmul_busy got ready=%b expected 0 before reset", busy);
    end
    checks++;
    if ({ir32, ov32, r32, rh32, z32, c32, v32} !== {1'b1, 68'b0}) begin
      errors++;
      $display("[TB] FAIL rstmul_clear got %h expected %h", {ir32, ov32, r32, rh32, z32, c32, v32}, {1'b1, 68'b0});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op32 = 3'd2; a32 = 32'd2; b32 = 32'd3; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    checks++;
    if ({ov32, r32, z32, c32, v32} !== {1'b1, 32'd5, 3'b000}) begin
      errors++;
      $display("[TB] FAIL rstmul_add got %h expected %h", {ov32, r32, z32, c32, v32}, {1'b1, 32'd5, 3'b000});
    end
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ov32) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("[TB] FAIL rstmul_stale got %0d pulses expected 0", stale);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
    iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_back_to_back();
    test_multu4();
    test_directed32();
    test_random();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
